// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel word to serial bit stream, one bit per clock, selectable bit order
// Build option: define SERIALIZER_PARITY_EN to append one even-parity bit after the data bits.
module byte_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_data_valid,
    input  logic             i_msb_first,
    output logic             o_data_ready,
    output logic             o_serial_out,
    output logic             o_serial_valid,
    output logic             o_frame_done,
    output logic             o_busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_msb;
    logic             w_head;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
`ifdef SERIALIZER_PARITY_EN
    logic             r_par;
`endif

    // The head bit always sits at one end of the shift register; the register moves toward it.
    assign w_head   = r_msb ? r_shift[WIDTH-1] : r_shift[0];
    assign w_last   = (r_cnt == LAST);
`ifdef SERIALIZER_PARITY_EN
    assign w_ready  = (r_state == IDLE) || (r_state == PARITY);
`else
    assign w_ready  = (r_state == IDLE) || ((r_state == SHIFT) && w_last);
`endif
    assign w_accept = i_data_valid && w_ready;

    assign o_data_ready = w_ready;
    assign o_busy       = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        o_serial_out   = 1'b0;
        o_serial_valid = 1'b0;
        o_frame_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nx = SHIFT;
            end
            SHIFT: begin
                o_serial_out   = w_head;
                o_serial_valid = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                if (w_last) w_state_nx = PARITY;
`else
                o_frame_done   = w_last;
                if (w_last) w_state_nx = w_accept ? SHIFT : IDLE;
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                o_serial_out   = r_par;
                o_serial_valid = 1'b1;
                o_frame_done   = 1'b1;
                w_state_nx     = w_accept ? SHIFT : IDLE;
            end
`endif
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_msb   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift <= i_data_in;
            r_cnt   <= '0;
            r_msb   <= i_msb_first;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (r_state == SHIFT) begin
            r_shift <= r_msb ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
`ifdef SERIALIZER_PARITY_EN
            r_par   <= r_par ^ w_head;
`endif
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - vector table plus scoreboard check of byte_serializer frames
// Honours SERIALIZER_PARITY_EN the same way as the design.
module tb_byte_serializer;
    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] i_data_in = '0;
    logic         i_data_valid = 1'b0;
    logic         i_msb_first = 1'b0;
    logic         o_data_ready;
    logic         o_serial_out;
    logic         o_serial_valid;
    logic         o_frame_done;
    logic         o_busy;

    byte_serializer #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data_in      (i_data_in),
        .i_data_valid   (i_data_valid),
        .i_msb_first    (i_msb_first),
        .o_data_ready   (o_data_ready),
        .o_serial_out   (o_serial_out),
        .o_serial_valid (o_serial_valid),
        .o_frame_done   (o_frame_done),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bit_v;
        logic last;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [7:0] seq;   // expected emission order, leftmost bit first
        logic       par;
    } vec_t;

    exp_t q[$];
    exp_t e_mon;
    vec_t vecs[8];
    int   total = 0;
    int   bad = 0;
    int   run = 0;
    int   last_run = 0;
    int   cyc;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_serial_valid) begin
                run++;
                if (q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e_mon = q.pop_front();
                    check("serial_out", int'(o_serial_out), int'(e_mon.bit_v));
                    check("frame_done", int'(o_frame_done), int'(e_mon.last));
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                check("idle_outputs", int'({o_serial_out, o_frame_done}), 0);
            end
        end
    end

    task automatic push_frame(input logic [7:0] seq, input logic par);
        for (int i = 0; i < W; i++) begin
            q.push_back('{bit_v: seq[W-1-i], last: (PAR == 0) && (i == W - 1)});
        end
        if (PAR != 0) q.push_back('{bit_v: par, last: 1'b1});
    endtask

    task automatic send(input logic [7:0] d, input logic m, input logic [7:0] seq, input logic par);
        int n;
        n = 0;
        @(negedge clk);
        i_data_in    = d;
        i_msb_first  = m;
        i_data_valid = 1'b1;
        while (!o_data_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", int'(n < 100), 1);
        push_frame(seq, par);
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!o_busy) break;
            c++;
        end
        check("idle_timeout", int'(c < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hC3, 1'b1, 8'b11000011, 1'b0};
        vecs[1] = '{8'h0C, 1'b0, 8'b00110000, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 8'b10100101, 1'b0};
        vecs[3] = '{8'h01, 1'b0, 8'b10000000, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 8'b10000000, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 8'b00000001, 1'b1};
        vecs[6] = '{8'h07, 1'b1, 8'b00000111, 1'b1};
        vecs[7] = '{8'h03, 1'b1, 8'b00000011, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_serial_valid", int'(o_serial_valid), 0);
        check("rst_serial_out", int'(o_serial_out), 0);
        check("rst_frame_done", int'(o_frame_done), 0);
        check("rst_busy", int'(o_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(o_data_ready), 1);

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].data, vecs[v].msb, vecs[v].seq, vecs[v].par);
            check("first_bit_latency", int'(o_serial_valid), 1);
            check("ready_low_mid_frame", int'(o_data_ready), 0);
            wait_idle(cyc);
            check("frame_len", cyc, FRAME);
        end

        // Back-to-back: second word accepted in the final cycle of the first.
        send(8'hC0, 1'b1, 8'b11000000, 1'b0);
        send(8'hA5, 1'b1, 8'b10100101, 1'b0);
        wait_idle(cyc);
        @(negedge clk);
        #1;
        check("b2b_contiguous", last_run, 2 * FRAME);

        // Reset mid-frame after three bits of 8'hFF.
        send(8'hFF, 1'b1, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_serial_valid", int'(o_serial_valid), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_serial_out", int'(o_serial_out), 0);
        check("abort_queue_left", q.size(), W + PAR - 3);
        q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("abort_ready", int'(o_data_ready), 1);
        check("abort_busy_after", int'(o_busy), 0);
        repeat (4) @(negedge clk);
        send(8'h5A, 1'b0, 8'b01011010, 1'b0);
        wait_idle(cyc);
        check("clean_frame_len", cyc, FRAME);

        // Inputs scrambled while the frame is in flight must not leak into it.
        send(8'h3C, 1'b1, 8'b00111100, 1'b0);
        for (int k = 0; k < FRAME - 1; k++) begin
            @(negedge clk);
            #2;
            i_data_in   = 8'($urandom);
            i_msb_first = 1'($urandom);
        end
        wait_idle(cyc);
        repeat (2) @(negedge clk);

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
